ahb_sram_slave: RTL and testbench
=================================

# ahb_sram_slave

AHB-Lite responder that terminates one slave port of the interconnect with a word-organised on-chip memory. It captures address-phase control, inserts a programmable number of wait states, performs byte/halfword/word writes and reads, and returns the two-cycle ERROR response for illegal accesses. It sits on the slave side of the AHB pass-through/interconnect and is the default memory target for bus-level bring-up.

## Interface
- `ADDR_WIDTH`, 32: HADDR width.
- `DATA_WIDTH`, 32: HWDATA/HRDATA width. Only 32 is supported.
- `MEM_AW`, 10: word-address bits. Memory is 2^MEM_AW words (4 KiB at default).
- `WAIT_STATES`, 1: wait cycles added to every OKAY data phase, 0..7.
- `hclk` in 1: bus clock, all logic on rising edge.
- `hresetn` in 1: asynchronous, active-low reset.
- `hsel` in 1: slave select from the decoder.
- `haddr` in ADDR_WIDTH: transfer address.
- `htrans` in 2: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `hsize` in 3: transfer size.
- `hwrite` in 1: 1 = write.
- `hburst` in 3, `hprot` in 4, `hmastlock` in 1: accepted, ignored.
- `hwdata` in DATA_WIDTH: write data, valid in the data phase.
- `hready` in 1: bus HREADY (previous transfer complete).
- `hreadyout` out 1: this slave's ready.
- `hresp` out 1: 0 = OKAY, 1 = ERROR.
- `hrdata` out DATA_WIDTH: read data.

## Operation
- Transfer is accepted on a rising edge when `hsel & hready & htrans[1]`. Accepting latches addr, size, write, and the error flag into data-phase registers.
- IDLE/BUSY, or an unselected cycle with `hready`=1, gives a zero-wait OKAY data phase.
- Error flag is set by any of:
  - `haddr[ADDR_WIDTH-1:MEM_AW+2]` != 0 (out of range).
  - `hsize` > 2.
  - Misalignment: halfword with `haddr[0]`=1, or word with `haddr[1:0]`!=0.
- FSM states:
  - IDLE: no pending phase; `hreadyout`=1, `hresp`=0.
    - Accepted legal transfer -> WAIT, or -> LAST if WAIT_STATES=0.
    - Accepted illegal transfer -> ERR1.
  - WAIT: `hreadyout`=0. Counter loads WAIT_STATES-1 on entry and decrements; at 0 -> LAST.
  - LAST: `hreadyout`=1, `hresp`=0. The write commits at this edge. Next state is decided by a new accept in this same cycle (as in IDLE), else -> IDLE.
  - ERR1: `hreadyout`=0, `hresp`=1. Always -> ERR2. Address inputs are ignored because `hready`=0.
  - ERR2: `hreadyout`=1, `hresp`=1. No memory access. A new accept in this cycle proceeds as from IDLE.
- Write byte lanes (little-endian) from the latched size and addr[1:0]:
  - byte: 4'b0001 << a[1:0].
  - half: 4'b0011 << a[1:0].
  - word: 4'b1111.
- Read: `hrdata` = mem[addr_q] combinationally during WAIT/LAST of a read. Otherwise 0.
- Read-after-write to the same word in back-to-back transfers returns the new data.
- Memory contents are not reset.

## Timing
- Reset values: state IDLE, `hreadyout`=1, `hresp`=0, `hrdata`=0, wait counter 0, data-phase registers cleared.
- OKAY data phase lasts WAIT_STATES+1 cycles. ERROR data phase is always exactly 2 cycles.
- Pipelined address phase overlapping LAST or ERR2 is accepted with no bubble.
- `hreadyout`/`hresp` come from state flops only; `hrdata` is combinational from flops and the array.
- Reset asserted mid-transfer: everything returns to reset values immediately. No partial write commits.

## Structure
- Shared package `ahb_pkg`:
  - HTRANS encodings, HRESP codes, HSIZE codes.
  - Width constants (ADDR/DATA/HBURST/HPROT).
  - FSM state typedef.
- Sub-module `ahb_wstrb_gen`: combinational size + addr[1:0] -> 4-bit byte strobe and misalign flag. Reusable by other slaves.
- The memory array is inferred inside the top level.

## Test plan
- Reset with `hresetn`=0, then release -> `hreadyout`=1, `hresp`=0, `hrdata`=0.
- WAIT_STATES=1: word write 0xDEADBEEF @0x10, then read @0x10 -> each data phase has `hreadyout` 0 then 1; read returns 0xDEADBEEF.
- Byte write 0xAA @0x11 over a word of 0x00000000, then word read @0x10 -> 0x0000AA00. Halfword write 0x1234 @0x12, then read -> 0x1234AA00.
- Word access @0x2000 (out of range) and halfword @0x3 -> two-cycle ERROR each: (0,1) then (1,1). Memory unchanged.
- WAIT_STATES=0, back-to-back NONSEQ write/read/write/read -> one cycle per transfer, no stalls, correct data.
- Reset asserted during WAIT of a write -> target word keeps its old value; outputs are at reset values in the same cycle.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, widths and slave FSM state type.
package ahb_pkg;

  localparam int AHB_ADDR_W   = 32;
  localparam int AHB_DATA_W   = 32;
  localparam int AHB_HBURST_W = 3;
  localparam int AHB_HPROT_W  = 4;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_WAIT = 3'd1;
  localparam state_t S_LAST = 3'd2;
  localparam state_t S_ERR1 = 3'd3;
  localparam state_t S_ERR2 = 3'd4;

endpackage

// File: rtl/ahb_wstrb_gen.sv
// Little-endian byte strobe and misalignment flag from
// transfer size and the low address bits.
module ahb_wstrb_gen
  import ahb_pkg::*;
(
  input  logic [2:0] size_i,
  input  logic [1:0] addr_i,
  output logic [3:0] strb_o,
  output logic       misalign_o
);

  always_comb begin
    strb_o     = 4'b0000;
    misalign_o = 1'b0;
    unique case (1'b1)
      (size_i == HSIZE_BYTE): begin
        strb_o = 4'b0001 << addr_i;
      end
      (size_i == HSIZE_HALF): begin
        strb_o     = 4'b0011 << addr_i;
        misalign_o = addr_i[0];
      end
      (size_i == HSIZE_WORD): begin
        strb_o     = 4'b1111;
        misalign_o = |addr_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder with programmable wait states
// and two-cycle ERROR response for illegal accesses.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_AW      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hsize,
  input  logic                  hwrite,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic                  hmastlock,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int         DEPTH = 1 << MEM_AW;
  localparam logic [2:0] WS_M1 = 3'(WAIT_STATES - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [MEM_AW+1:0] addr_q, addr_d;
  logic [2:0]        size_q, size_d;
  logic              write_q, write_d;
  logic              err_q, err_d;

  logic              accept;
  logic              mis_in;
  logic              err_in;
  logic [3:0]        strb_q;
  logic [3:0]        unused_strb;
  logic              unused_mis;
  logic              unused_ok;
  logic [MEM_AW-1:0] widx;

  assign unused_ok = ^{hburst, hprot, hmastlock, unused_strb, unused_mis};

  assign accept = hsel & hready & htrans[1];
  assign widx   = addr_q[MEM_AW+1:2];

  ahb_wstrb_gen u_chk (
    .size_i     (hsize),
    .addr_i     (haddr[1:0]),
    .strb_o     (unused_strb),
    .misalign_o (mis_in)
  );

  ahb_wstrb_gen u_strb (
    .size_i     (size_q),
    .addr_i     (addr_q[1:0]),
    .strb_o     (strb_q),
    .misalign_o (unused_mis)
  );

  assign err_in = (|haddr[ADDR_WIDTH-1:MEM_AW+2])
                | (hsize > HSIZE_WORD)
                | mis_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    err_d   = err_q;
    if (accept) begin
      addr_d  = haddr[MEM_AW+1:0];
      size_d  = hsize;
      write_d = hwrite;
      err_d   = err_in;
    end
    unique case (1'b1)
      (state_q == S_WAIT): begin
        if (cnt_q == 3'd0) state_d = S_LAST;
        else               cnt_d   = cnt_q - 3'd1;
      end
      (state_q == S_ERR1): begin
        state_d = S_ERR2;
      end
      default: begin
        // IDLE, LAST and ERR2 all take a pipelined address phase
        state_d = S_IDLE;
        if (accept) begin
          if (err_in) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d = S_LAST;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS_M1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      size_q  <= 3'd0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge hclk) begin
    if (state_q == S_LAST && write_q && !err_q) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_q[b]) mem[widx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  assign hreadyout = (state_q == S_IDLE) | (state_q == S_LAST)
                   | (state_q == S_ERR2);
  assign hresp     = (state_q == S_ERR1) | (state_q == S_ERR2);
  assign hrdata    = (!write_q && (state_q == S_WAIT || state_q == S_LAST))
                   ? mem[widx] : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: one slave with 1 wait state, one with none,
// each with its own hreadyout looped back as hready.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel0, hsel1;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic        hwrite, hmastlock;
  logic        rdy0, rdy1, resp0, resp1;
  logic [31:0] rd0, rd1;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  ahb_sram_slave #(.WAIT_STATES(1)) dut1 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel1), .haddr(haddr),
    .htrans(htrans), .hsize(hsize), .hwrite(hwrite), .hburst(hburst),
    .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata),
    .hready(rdy1), .hreadyout(rdy1), .hresp(resp1), .hrdata(rd1)
  );

  ahb_sram_slave #(.WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr),
    .htrans(htrans), .hsize(hsize), .hwrite(hwrite), .hburst(hburst),
    .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata),
    .hready(rdy0), .hreadyout(rdy0), .hresp(resp0), .hrdata(rd0)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge hclk);
    #1;
  endtask

  task automatic xfer1(input logic wr, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input string tag);
    hsel1  = 1'b1;
    haddr  = a;
    htrans = HTRANS_NONSEQ;
    hwrite = wr;
    hsize  = sz;
    step();
    hsel1  = 1'b0;
    htrans = HTRANS_IDLE;
    hwdata = wd;
    chk({tag, ".rdy_p1"}, 32'(rdy1), 32'd0);
    chk({tag, ".resp_p1"}, 32'(resp1), 32'(exp_err));
    if (!wr && !exp_err) chk({tag, ".rd_p1"}, rd1, exp_rd);
    step();
    chk({tag, ".rdy_p2"}, 32'(rdy1), 32'd1);
    chk({tag, ".resp_p2"}, 32'(resp1), 32'(exp_err));
    if (!wr && !exp_err) chk({tag, ".rd_p2"}, rd1, exp_rd);
    step();
    chk({tag, ".idle_rd"}, rd1, 32'd0);
  endtask

  initial begin
    hsel0 = 1'b0; hsel1 = 1'b0; haddr = '0; hwdata = '0;
    htrans = HTRANS_IDLE; hsize = HSIZE_WORD; hwrite = 1'b0;
    hburst = 3'd0; hprot = 4'd0; hmastlock = 1'b0;

    step();
    step();
    hresetn = 1'b1;
    step();
    chk("rst.rdy1", 32'(rdy1), 32'd1);
    chk("rst.resp1", 32'(resp1), 32'd0);
    chk("rst.rd1", rd1, 32'd0);
    chk("rst.rdy0", 32'(rdy0), 32'd1);

    xfer1(1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, 32'h0, 1'b0, "w_dead");
    xfer1(1'b0, 32'h10, HSIZE_WORD, 32'h0, 32'hDEADBEEF, 1'b0, "r_dead");

    xfer1(1'b1, 32'h10, HSIZE_WORD, 32'h0, 32'h0, 1'b0, "w_zero");
    xfer1(1'b1, 32'h11, HSIZE_BYTE, 32'h0000AA00, 32'h0, 1'b0, "w_byte");
    xfer1(1'b0, 32'h10, HSIZE_WORD, 32'h0, 32'h0000AA00, 1'b0, "r_byte");
    xfer1(1'b1, 32'h12, HSIZE_HALF, 32'h12340000, 32'h0, 1'b0, "w_half");
    xfer1(1'b0, 32'h10, HSIZE_WORD, 32'h0, 32'h1234AA00, 1'b0, "r_half");

    xfer1(1'b1, 32'h0, HSIZE_WORD, 32'h11111111, 32'h0, 1'b0, "w_base");
    xfer1(1'b1, 32'h2000, HSIZE_WORD, 32'hFFFFFFFF, 32'h0, 1'b1, "e_oor");
    xfer1(1'b1, 32'h3, HSIZE_HALF, 32'hFFFFFFFF, 32'h0, 1'b1, "e_mis");
    xfer1(1'b1, 32'h0, 3'd3, 32'hFFFFFFFF, 32'h0, 1'b1, "e_size");
    xfer1(1'b0, 32'h0, HSIZE_WORD, 32'h0, 32'h11111111, 1'b0, "r_unch");

    // zero-wait slave: back-to-back pipelined write/read/write/read
    hsel0 = 1'b1; htrans = HTRANS_NONSEQ; hsize = HSIZE_WORD;
    haddr = 32'h20; hwrite = 1'b1;
    step();
    chk("b2b.rdy_a", 32'(rdy0), 32'd1);
    hwdata = 32'hCAFEF00D; haddr = 32'h20; hwrite = 1'b0;
    step();
    chk("b2b.rdy_b", 32'(rdy0), 32'd1);
    chk("b2b.rd_b", rd0, 32'hCAFEF00D);
    haddr = 32'h24; hwrite = 1'b1; hwdata = 32'h0;
    step();
    chk("b2b.rdy_c", 32'(rdy0), 32'd1);
    hwdata = 32'h01020304; haddr = 32'h24; hwrite = 1'b0;
    step();
    chk("b2b.rdy_d", 32'(rdy0), 32'd1);
    chk("b2b.resp_d", 32'(resp0), 32'd0);
    chk("b2b.rd_d", rd0, 32'h01020304);
    hsel0 = 1'b0; htrans = HTRANS_IDLE;
    step();
    chk("b2b.idle_rd", rd0, 32'd0);

    // reset during the wait state of a write must not commit it
    xfer1(1'b1, 32'h40, HSIZE_WORD, 32'h55555555, 32'h0, 1'b0, "w_old");
    xfer1(1'b0, 32'h40, HSIZE_WORD, 32'h0, 32'h55555555, 1'b0, "r_old");
    hsel1 = 1'b1; haddr = 32'h40; htrans = HTRANS_NONSEQ;
    hwrite = 1'b1; hsize = HSIZE_WORD;
    step();
    hsel1 = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h99999999;
    chk("rstw.rdy_wait", 32'(rdy1), 32'd0);
    #1;
    hresetn = 1'b0;
    #1;
    chk("rstw.rdy", 32'(rdy1), 32'd1);
    chk("rstw.resp", 32'(resp1), 32'd0);
    chk("rstw.rd", rd1, 32'd0);
    step();
    step();
    hresetn = 1'b1;
    step();
    xfer1(1'b0, 32'h40, HSIZE_WORD, 32'h0, 32'h55555555, 1'b0, "r_kept");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
